// File: rtl/datapath_hazard_pkg.sv
// Shared encodings for the pipelined RV32I datapath: result-select and forwarding
// codes, the bubble instruction, the decoded-control bundle and the forwarding rule.
package datapath_hazard_pkg;

    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC4 = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic [2:0] alu_control;
        logic       alu_src;
    } ctrl_t;

    // M has priority over W: it holds the younger result.
    function automatic logic [1:0] fwd_sel(input logic rw_m, input logic [4:0] rd_m,
                                           input logic rw_w, input logic [4:0] rd_w,
                                           input logic [4:0] rs);
        if (rw_m && rd_m != 5'd0 && rd_m == rs) return FWD_MEM;
        if (rw_w && rd_w != 5'd0 && rd_w == rs) return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/datapath_hazard_if.sv
// Controller decode, instruction/data memory and debug signals of the datapath.
// master = datapath side, slave = controller/memory side.
interface datapath_hazard_if #(parameter int XLEN = 32);
    logic [1:0]      ResultSrc;
    logic            MemWriteD;
    logic            ALUSrc;
    logic            RegWrite;
    logic [1:0]      ImmSrc;
    logic [2:0]      ALUControl;
    logic            Jump;
    logic            Branch;
    logic [XLEN-1:0] PC;
    logic [31:0]     Instr;
    logic [6:0]      op;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [XLEN-1:0] ALUResult;
    logic [XLEN-1:0] WriteData;
    logic            MemWriteM;
    logic [XLEN-1:0] ReadData;
    logic            StallD;
    logic            FlushE;

    modport master (
        input  ResultSrc, MemWriteD, ALUSrc, RegWrite, ImmSrc, ALUControl, Jump, Branch,
        input  Instr, ReadData,
        output PC, op, funct3, funct7b5, ALUResult, WriteData, MemWriteM, StallD, FlushE
    );

    modport slave (
        output ResultSrc, MemWriteD, ALUSrc, RegWrite, ImmSrc, ALUControl, Jump, Branch,
        output Instr, ReadData,
        input  PC, op, funct3, funct7b5, ALUResult, WriteData, MemWriteM, StallD, FlushE
    );
endinterface

// File: rtl/datapath_hazard_hazard_unit.sv
// Combinational hazard detection: load-use stall and taken-redirect flush.
module hazard_unit
    import datapath_hazard_pkg::*;
#(
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic [4:0] rs1_id,
    input  logic [4:0] rs2_id,
    input  logic [4:0] rd_ex,
    input  logic [1:0] result_src_ex,
    input  logic       pc_src_ex,
    output logic       stall_if,
    output logic       stall_id,
    output logic       flush_id,
    output logic       flush_ex
);
    logic lw_stall;

    always_comb begin
        lw_stall = HAZARD_EN && (result_src_ex == RESULT_MEM) && (rd_ex != 5'd0) &&
                   ((rd_ex == rs1_id) || (rd_ex == rs2_id));
        flush_id = HAZARD_EN && pc_src_ex;
        // A redirect kills the waiting ID instruction, so holding it is pointless.
        stall_if = lw_stall && !pc_src_ex;
        stall_id = stall_if;
        flush_ex = lw_stall || flush_id;
    end
endmodule

// File: rtl/datapath_hazard.sv
// 5-stage RV32I datapath (IF/ID/EX/MEM/WB) with M/W forwarding, load-use stall
// and taken branch/jump flush. Decode lives in the external controller.
module datapath_hazard #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = datapath_hazard_pkg::NOP_INSTR,
    parameter bit              HAZARD_EN = 1'b1
) (
    input logic               clk,
    input logic               reset,
    datapath_hazard_if.master bus
);
    import datapath_hazard_pkg::*;

    typedef struct packed {
        logic [31:0] instr; logic [XLEN-1:0] pc, pc4;
    } if_id_t;
    typedef struct packed {
        ctrl_t ctrl; logic [XLEN-1:0] rd1, rd2, pc, imm, pc4; logic [4:0] rs1, rs2, rd;
    } id_ex_t;
    typedef struct packed {
        logic reg_write; logic [1:0] result_src; logic mem_write;
        logic [XLEN-1:0] alu, wdata, pc4; logic [4:0] rd;
    } ex_mem_t;
    typedef struct packed {
        logic reg_write; logic [1:0] result_src;
        logic [XLEN-1:0] alu, rdata, pc4; logic [4:0] rd;
    } mem_wb_t;

    localparam if_id_t IFID_RST = '{instr: NOP_INSTR, default: '0};

    logic [XLEN-1:0] pc_f_q, pc_f_d, pc4_f;
    if_id_t          ifid_q, ifid_d;
    id_ex_t          idex_q, idex_d;
    ex_mem_t         exmem_q, exmem_d;
    mem_wb_t         memwb_q, memwb_d;
    logic [XLEN-1:0] rf_q [32];
    logic [XLEN-1:0] rf_d [32];

    logic [4:0]      rs1_id, rs2_id;
    logic [XLEN-1:0] rd1_id, rd2_id, imm_id;
    logic [31:0]     imm32;
    ctrl_t           ctrl_id;
    logic [1:0]      fwd_a, fwd_b;
    logic [XLEN-1:0] src_a, fwd_rs2, src_b, alu_res, pc_tgt_ex, result_w;
    logic            pc_src_ex, rf_we;
    logic            stall_if, stall_id, flush_id, flush_ex;

    hazard_unit #(.HAZARD_EN(HAZARD_EN)) u_hazard (
        .rs1_id        (rs1_id),
        .rs2_id        (rs2_id),
        .rd_ex         (idex_q.rd),
        .result_src_ex (idex_q.ctrl.result_src),
        .pc_src_ex     (pc_src_ex),
        .stall_if      (stall_if),
        .stall_id      (stall_id),
        .flush_id      (flush_id),
        .flush_ex      (flush_ex)
    );

    always_comb begin
        case (memwb_q.result_src)
            RESULT_MEM: result_w = memwb_q.rdata;
            RESULT_PC4: result_w = memwb_q.pc4;
            default:    result_w = memwb_q.alu;
        endcase
        rf_we = reset && memwb_q.reg_write && (memwb_q.rd != 5'd0);
        rf_d  = rf_q;
        if (rf_we) rf_d[memwb_q.rd] = result_w;

        // ID: write-through read so WB and ID can share a cycle
        rs1_id = ifid_q.instr[19:15];
        rs2_id = ifid_q.instr[24:20];
        rd1_id = (rs1_id == 5'd0) ? '0 : (rf_we && memwb_q.rd == rs1_id) ? result_w : rf_q[rs1_id];
        rd2_id = (rs2_id == 5'd0) ? '0 : (rf_we && memwb_q.rd == rs2_id) ? result_w : rf_q[rs2_id];
        case (bus.ImmSrc)
            2'b00:   imm32 = {{20{ifid_q.instr[31]}}, ifid_q.instr[31:20]};
            2'b01:   imm32 = {{20{ifid_q.instr[31]}}, ifid_q.instr[31:25], ifid_q.instr[11:7]};
            2'b10:   imm32 = {{20{ifid_q.instr[31]}}, ifid_q.instr[7], ifid_q.instr[30:25],
                              ifid_q.instr[11:8], 1'b0};
            default: imm32 = {{12{ifid_q.instr[31]}}, ifid_q.instr[19:12], ifid_q.instr[20],
                              ifid_q.instr[30:21], 1'b0};
        endcase
        imm_id = XLEN'($signed(imm32));
        ctrl_id             = '0;
        ctrl_id.reg_write   = bus.RegWrite;
        ctrl_id.result_src  = bus.ResultSrc;
        ctrl_id.mem_write   = bus.MemWriteD;
        ctrl_id.jump        = bus.Jump;
        ctrl_id.branch      = bus.Branch;
        ctrl_id.alu_control = bus.ALUControl;
        ctrl_id.alu_src     = bus.ALUSrc;

        // EX
        fwd_a = fwd_sel(exmem_q.reg_write, exmem_q.rd, memwb_q.reg_write, memwb_q.rd, idex_q.rs1);
        fwd_b = fwd_sel(exmem_q.reg_write, exmem_q.rd, memwb_q.reg_write, memwb_q.rd, idex_q.rs2);
        case (fwd_a)
            FWD_MEM: src_a = exmem_q.alu;
            FWD_WB:  src_a = result_w;
            default: src_a = idex_q.rd1;
        endcase
        case (fwd_b)
            FWD_MEM: fwd_rs2 = exmem_q.alu;
            FWD_WB:  fwd_rs2 = result_w;
            default: fwd_rs2 = idex_q.rd2;
        endcase
        src_b = idex_q.ctrl.alu_src ? idex_q.imm : fwd_rs2;
        case (idex_q.ctrl.alu_control)
            3'b000:  alu_res = src_a + src_b;
            3'b001:  alu_res = src_a - src_b;
            3'b010:  alu_res = src_a & src_b;
            3'b011:  alu_res = src_a | src_b;
            3'b101:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default: alu_res = '0;
        endcase
        pc_src_ex = idex_q.ctrl.jump || (idex_q.ctrl.branch && (alu_res == '0));
        pc_tgt_ex = idex_q.pc + idex_q.imm;

        // next state: flush > stall > load
        pc4_f  = pc_f_q + XLEN'(4);
        pc_f_d = pc_src_ex ? pc_tgt_ex : (stall_if ? pc_f_q : pc4_f);

        ifid_d = '{instr: bus.Instr, pc: pc_f_q, pc4: pc4_f};
        if (flush_id)      ifid_d = IFID_RST;
        else if (stall_id) ifid_d = ifid_q;

        idex_d = '{ctrl: ctrl_id, rd1: rd1_id, rd2: rd2_id, pc: ifid_q.pc, imm: imm_id,
                   pc4: ifid_q.pc4, rs1: rs1_id, rs2: rs2_id, rd: ifid_q.instr[11:7]};
        if (flush_ex) idex_d = '0;

        exmem_d = '{reg_write: idex_q.ctrl.reg_write, result_src: idex_q.ctrl.result_src,
                    mem_write: idex_q.ctrl.mem_write, alu: alu_res, wdata: fwd_rs2,
                    pc4: idex_q.pc4, rd: idex_q.rd};
        memwb_d = '{reg_write: exmem_q.reg_write, result_src: exmem_q.result_src,
                    alu: exmem_q.alu, rdata: bus.ReadData, pc4: exmem_q.pc4, rd: exmem_q.rd};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_f_q  <= RESET_PC;
            ifid_q  <= IFID_RST;
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            pc_f_q  <= pc_f_d;
            ifid_q  <= ifid_d;
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    // Register contents survive reset; the write enable is gated by reset instead.
    always_ff @(posedge clk) rf_q <= rf_d;

    assign bus.PC        = pc_f_q;
    assign bus.op        = ifid_q.instr[6:0];
    assign bus.funct3    = ifid_q.instr[14:12];
    assign bus.funct7b5  = ifid_q.instr[30];
    assign bus.ALUResult = exmem_q.alu;
    assign bus.WriteData = exmem_q.wdata;
    assign bus.MemWriteM = exmem_q.mem_write;
    assign bus.StallD    = stall_id;
    assign bus.FlushE    = flush_ex;
endmodule

// File: tb/tb_datapath_hazard.sv
// Directed bench: two datapaths (hazards on / legacy off) run small hand-assembled
// programs; a behavioural controller and memories sit around each one.
module tb_datapath_hazard;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       alu_src;
        logic [1:0] imm_src;
        logic [2:0] alu_control;
    } ctl_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    int   stall_cnt0 = 0, stall_cnt1 = 0, flush_cnt1 = 0;
    logic [63:0] st0 [$];
    logic [63:0] st1 [$];

    logic [31:0] imem0 [64];
    logic [31:0] imem1 [64];
    logic [31:0] dmem0 [64];
    logic [31:0] dmem1 [64];
    logic [31:0] pc0_exp [12];
    logic [31:0] pc1_exp [7];
    logic [11:0] stall0_exp = 12'b0000_0000_1000;
    logic [11:0] flush0_exp = 12'b0000_0100_1000;
    ctl_t c0, c1;

    always #5 clk = ~clk;

    datapath_hazard_if #(.XLEN(32)) if0 ();
    datapath_hazard_if #(.XLEN(32)) if1 ();

    datapath_hazard #(.HAZARD_EN(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(if0.master));
    datapath_hazard #(.HAZARD_EN(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(if1.master));

    function automatic ctl_t decode(input logic [6:0] op, input logic [2:0] f3, input logic f7b5);
        ctl_t       c;
        logic [1:0] alu_op;
        c = '0;
        alu_op = 2'b00;
        case (op)
            7'b0000011: begin c.reg_write = 1'b1; c.result_src = 2'b01; c.alu_src = 1'b1; end
            7'b0100011: begin c.mem_write = 1'b1; c.alu_src = 1'b1; c.imm_src = 2'b01; end
            7'b0110011: begin c.reg_write = 1'b1; alu_op = 2'b10; end
            7'b0010011: begin c.reg_write = 1'b1; c.alu_src = 1'b1; alu_op = 2'b10; end
            7'b1100011: begin c.branch = 1'b1; c.imm_src = 2'b10; alu_op = 2'b01; end
            7'b1101111: begin c.reg_write = 1'b1; c.jump = 1'b1; c.imm_src = 2'b11;
                              c.result_src = 2'b10; end
            default: ;
        endcase
        case (alu_op)
            2'b01: c.alu_control = 3'b001;
            2'b10: case (f3)
                3'b000:  c.alu_control = (op[5] && f7b5) ? 3'b001 : 3'b000;
                3'b010:  c.alu_control = 3'b101;
                3'b110:  c.alu_control = 3'b011;
                3'b111:  c.alu_control = 3'b010;
                default: c.alu_control = 3'b000;
            endcase
            default: c.alu_control = 3'b000;
        endcase
        return c;
    endfunction

    always_comb begin
        c0 = decode(if0.op, if0.funct3, if0.funct7b5);
        c1 = decode(if1.op, if1.funct3, if1.funct7b5);
    end

    assign if0.RegWrite = c0.reg_write;   assign if1.RegWrite = c1.reg_write;
    assign if0.ResultSrc = c0.result_src; assign if1.ResultSrc = c1.result_src;
    assign if0.MemWriteD = c0.mem_write;  assign if1.MemWriteD = c1.mem_write;
    assign if0.Jump = c0.jump;            assign if1.Jump = c1.jump;
    assign if0.Branch = c0.branch;        assign if1.Branch = c1.branch;
    assign if0.ALUSrc = c0.alu_src;       assign if1.ALUSrc = c1.alu_src;
    assign if0.ImmSrc = c0.imm_src;       assign if1.ImmSrc = c1.imm_src;
    assign if0.ALUControl = c0.alu_control;
    assign if1.ALUControl = c1.alu_control;
    assign if0.Instr = imem0[if0.PC[7:2]];
    assign if1.Instr = imem1[if1.PC[7:2]];
    assign if0.ReadData = dmem0[if0.ALUResult[7:2]];
    assign if1.ReadData = dmem1[if1.ALUResult[7:2]];

    always @(negedge clk) begin
        if (mon_en) begin
            if (if0.MemWriteM) st0.push_back({if0.ALUResult, if0.WriteData});
            if (if1.MemWriteM) st1.push_back({if1.ALUResult, if1.WriteData});
            stall_cnt0 += int'(if0.StallD);
            stall_cnt1 += int'(if1.StallD);
            flush_cnt1 += int'(if1.FlushE);
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " PC0"}, 64'(if0.PC), 64'h0);
        chk({tag, " PC1"}, 64'(if1.PC), 64'h0);
        chk({tag, " MemWriteM0"}, 64'(if0.MemWriteM), 64'h0);
        chk({tag, " MemWriteM1"}, 64'(if1.MemWriteM), 64'h0);
        chk({tag, " op0"}, 64'(if0.op), 64'h13);
        chk({tag, " ALUResult0"}, 64'(if0.ALUResult), 64'h0);
        chk({tag, " WriteData0"}, 64'(if0.WriteData), 64'h0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            imem0[i] = NOP; imem1[i] = NOP; dmem0[i] = '0; dmem1[i] = '0;
        end
        imem0[0]  = 32'h0050_0093;  // addi x1,x0,5
        imem0[1]  = 32'h0010_8133;  // add  x2,x1,x1
        imem0[2]  = 32'h0000_2183;  // lw   x3,0(x0)
        imem0[3]  = 32'h0031_8233;  // add  x4,x3,x3
        imem0[4]  = 32'h0000_0463;  // beq  x0,x0,+8
        imem0[5]  = 32'h0010_2623;  // sw   x1,12(x0)  (must be squashed)
        imem0[6]  = 32'h0070_0293;  // addi x5,x0,7
        imem0[7]  = 32'h0050_2223;  // sw   x5,4(x0)
        imem0[8]  = 32'h0020_2823;  // sw   x2,16(x0)
        imem0[9]  = 32'h0040_2A23;  // sw   x4,20(x0)
        imem0[10] = 32'h0000_006F;  // jal  x0,0
        dmem0[0]  = 32'h2A;
        imem1[0]  = 32'h0080_2183;  // lw   x3,8(x0)
        imem1[1]  = 32'h0031_8233;  // add  x4,x3,x3
        imem1[2]  = 32'h0040_2023;  // sw   x4,0(x0)
        imem1[3]  = 32'h0030_2223;  // sw   x3,4(x0)
        imem1[4]  = 32'h0000_006F;  // jal  x0,0
        dmem1[2]  = 32'h2A;
        pc0_exp = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h10, 32'h14,
                    32'h18, 32'h18, 32'h1C, 32'h20, 32'h24, 32'h28};
        pc1_exp = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h10};

        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        mon_en = 1'b1;
        chk_reset("reset");

        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (k <= 12) begin
                chk($sformatf("pc0 k%0d", k), 64'(if0.PC), 64'(pc0_exp[k-1]));
                chk($sformatf("stall0 k%0d", k), 64'(if0.StallD), 64'(stall0_exp[k-1]));
                chk($sformatf("flush0 k%0d", k), 64'(if0.FlushE), 64'(flush0_exp[k-1]));
            end
            if (k <= 7) begin
                chk($sformatf("pc1 k%0d", k), 64'(if1.PC), 64'(pc1_exp[k-1]));
                chk($sformatf("stall1 k%0d", k), 64'(if1.StallD), 64'h0);
            end
            case (k)
                4: begin
                    chk("add x2 M-fwd", 64'(if0.ALUResult), 64'd10);
                    chk("legacy add x4", 64'(if1.ALUResult), 64'd16);
                end
                7:  chk("add x4 after load", 64'(if0.ALUResult), 64'h54);
                8:  chk("beq in M no store", 64'(if0.MemWriteM), 64'h0);
                9:  chk("squashed sw", 64'(if0.MemWriteM), 64'h0);
                11: chk("no store before sw", 64'(if0.MemWriteM), 64'h0);
                12: begin
                    chk("sw x5 MemWriteM", 64'(if0.MemWriteM), 64'h1);
                    chk("sw x5 ALUResult", 64'(if0.ALUResult), 64'h4);
                    chk("sw x5 WriteData", 64'(if0.WriteData), 64'h7);
                end
                default: ;
            endcase
        end

        chk("stall pulses dut0", 64'(stall_cnt0), 64'd1);
        chk("stall pulses dut1", 64'(stall_cnt1), 64'd0);
        chk("flush pulses dut1", 64'(flush_cnt1), 64'd0);
        chk("stores dut0", 64'(st0.size()), 64'd3);
        if (st0.size() == 3) begin
            chk("store0[0]", st0[0], {32'd4, 32'd7});
            chk("store0[1]", st0[1], {32'd16, 32'd10});
            chk("store0[2]", st0[2], {32'd20, 32'h54});
        end
        chk("stores dut1", 64'(st1.size()), 64'd2);
        if (st1.size() == 2) begin
            chk("store1[0]", st1[0], {32'd0, 32'd16});
            chk("store1[1]", st1[1], {32'd4, 32'h2A});
        end

        // reset in the middle of the jal loop
        mon_en = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk_reset("mid reset");
        @(negedge clk);
        chk("pc0 after mid reset", 64'(if0.PC), 64'h4);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
